i_writeback: RTL



---
 rtl/i_pipe_pkg.sv | 31 +++
 rtl/i_wb_bypass.sv | 35 +++
 rtl/i_writeback.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/i_pipe_pkg.sv
// i_pipe_pkg
//   Shared definitions for the write-back stage of the five-stage pipeline:
//   write-back control bit positions, the write-back FSM state type, the
//   hard-wired zero register index, and the write-data select helper.
//   Imported by i_writeback and i_wb_bypass.

package i_pipe_pkg;

    // Bit positions inside the 2-bit write-back control field.
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    // Register $0 is hard-wired to zero; writes to it must not reach the file.
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOAD = 2'd1,
        ST_WRITE     = 2'd2
    } wb_state_e;

    // Final write-back mux: load data for loads, ALU result otherwise.
    function automatic logic [31:0] wb_select(
        input logic        mem_to_reg,
        input logic [31:0] load_data,
        input logic [31:0] alu_result
    );
        return mem_to_reg ? load_data : alu_result;
    endfunction

endpackage

// File: rtl/i_wb_bypass.sv
// i_wb_bypass
//   Same-cycle write-to-read bypass between the write-back register-file
//   write port and the two decode read ports. Purely combinational.
//
//   Ports:
//     wr_en, wr_addr, wr_data  : register-file write port being driven this cycle
//     rs, rt                   : decode read addresses
//     rdata1, rdata2           : raw register-file read data
//     fwd1, fwd2               : read data with the in-flight write forwarded

import i_pipe_pkg::*;

module i_wb_bypass (
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    output logic [31:0] fwd1,
    output logic [31:0] fwd2
);

    // wr_en is already suppressed for $0, so no separate zero-register check.
    logic hit1;
    logic hit2;

    assign hit1 = wr_en && (wr_addr == rs);
    assign hit2 = wr_en && (wr_addr == rt);

    assign fwd1 = hit1 ? wr_data : rdata1;
    assign fwd2 = hit2 ? wr_data : rdata2;

endmodule

// File: rtl/i_writeback.sv
// i_writeback
//   Write-back stage: accepts one retiring instruction from the memory stage
//   over a valid/ready handshake, waits for load data when needed, then
//   drives the register-file write port for exactly one cycle.
//
//   Optional feature macro: I_WB_BYPASS_EN
//     defined   -> id_* bypass ports exist and forward the current write to
//                  the decode read ports in the same cycle
//     undefined -> no bypass ports; decode relies on a write-first file
//
//   Ports:
//     clk, rst_n                  : clock, synchronous active-low reset
//     mem_valid / wb_ready        : handshake from the memory stage
//     mem_wb_ctl                  : [1] reg_write, [0] mem_to_reg
//     mem_alu_result, mem_write_reg : ALU result and destination register
//     dmem_rvalid, dmem_rdata     : load data strobe and data
//     wb_flush                    : kill pending load / block acceptance
//     MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data : register-file write port
//     retired_cnt                 : wrapping count of retired instructions
//     wb_err                      : sticky, load data arrived when none expected
//     id_rs, id_rt, id_rdata1, id_rdata2, id_fwd1, id_fwd2 : bypass (optional)

import i_pipe_pkg::*;

module i_writeback #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    output logic             wb_ready,
    input  logic [1:0]       mem_wb_ctl,
    input  logic [31:0]      mem_alu_result,
    input  logic [4:0]       mem_write_reg,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    input  logic             wb_flush,
    output logic [4:0]       MEM_WB_rd,
    output logic             MEM_WB_reg_write,
    output logic [31:0]      WB_mux5_write_data,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             wb_err
`ifdef I_WB_BYPASS_EN
    ,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [31:0]      id_rdata1,
    input  logic [31:0]      id_rdata2,
    output logic [31:0]      id_fwd1,
    output logic [31:0]      id_fwd2
`endif
);

    wb_state_e        state_p1;
    wb_state_e        state_nxt;
    logic             accept;
    logic             load_done;

    logic [1:0]       ctl_p1;
    logic [31:0]      alu_p1;
    logic [4:0]       rd_p1;
    logic [31:0]      load_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             err_p1;

    // Ready depends on state only, so the memory stage never sees a loop
    // through its own valid.
    assign wb_ready  = (state_p1 != ST_WAIT_LOAD);
    assign accept    = mem_valid && wb_ready && !wb_flush;
    // Flush wins over a same-cycle load strobe.
    assign load_done = (state_p1 == ST_WAIT_LOAD) && dmem_rvalid && !wb_flush;

    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            ST_IDLE, ST_WRITE: begin
                if (accept) begin
                    state_nxt = mem_wb_ctl[WB_MEM_TO_REG] ? ST_WAIT_LOAD : ST_WRITE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                if (wb_flush) begin
                    state_nxt = ST_IDLE;
                end else if (dmem_rvalid) begin
                    state_nxt = ST_WRITE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- stage p1: latched instruction, load data, counters ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p1 <= ST_IDLE;
            ctl_p1   <= '0;
            alu_p1   <= '0;
            rd_p1    <= '0;
            load_p1  <= '0;
            cnt_p1   <= '0;
            err_p1   <= 1'b0;
        end else begin
            state_p1 <= state_nxt;
            if (accept) begin
                ctl_p1 <= mem_wb_ctl;
                alu_p1 <= mem_alu_result;
                rd_p1  <= mem_write_reg;
            end
            if (load_done) begin
                load_p1 <= dmem_rdata;
            end
            if (state_p1 == ST_WRITE) begin
                cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
            // A strobe with no load outstanding is dropped and flagged.
            if (dmem_rvalid && (state_p1 != ST_WAIT_LOAD)) begin
                err_p1 <= 1'b1;
            end
        end
    end

    // Write port is decoded from flops and state only. $0 writes retire
    // (count and leave WRITE) but never assert the enable.
    assign MEM_WB_reg_write   = (state_p1 == ST_WRITE) && ctl_p1[WB_REG_WRITE]
                                && (rd_p1 != REG_ZERO);
    assign MEM_WB_rd          = rd_p1;
    assign WB_mux5_write_data = wb_select(ctl_p1[WB_MEM_TO_REG], load_p1, alu_p1);
    assign retired_cnt        = cnt_p1;
    assign wb_err             = err_p1;

`ifdef I_WB_BYPASS_EN
    i_wb_bypass u_bypass (
        .wr_en   (MEM_WB_reg_write),
        .wr_addr (MEM_WB_rd),
        .wr_data (WB_mux5_write_data),
        .rs      (id_rs),
        .rt      (id_rt),
        .rdata1  (id_rdata1),
        .rdata2  (id_rdata2),
        .fwd1    (id_fwd1),
        .fwd2    (id_fwd2)
    );
`endif

endmodule
